sdram_arbiter: RTL
==================

Name: sdram_arbiter

Overview:
- Central SDRAM command arbiter; the grant side of the refresh/write/read request handshakes.
- Receives `ref_req`, `wr_req` and `rd_req` from the sub-controllers and issues one-cycle enable pulses.
- Tracks which owner holds the bus and muxes that owner's cmd/addr/bank onto the SDRAM pins.
- Sits between `sdram_init`, `sdram_auto_refresh`, the write/read sub-controllers and the top-level SDRAM pads.

Parameters:
- NOP, 4'b0111, `{cs_n,ras_n,cas_n,we_n}` idle command.
- WDOG_MAX, 1023, cycles an owner may hold the bus before forced release.
- AW, 12, SDRAM address width.

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- flag_init_end  in  1  init sequence complete (pulse or level)
- init_cmd / init_addr / init_bank  in  4/AW/2  init module pins
- ref_req  in  1  refresh request (level, held until ref_en)
- flag_ref_end  in  1  refresh sequence complete (1-cycle pulse)
- ref_cmd / ref_addr / ref_bank  in  4/AW/2  refresh pins
- wr_req / wr_end  in  1/1  write request level; write done pulse
- wr_cmd / wr_addr / wr_bank  in  4/AW/2
- rd_req / rd_end  in  1/1  read request level; read done pulse
- rd_cmd / rd_addr / rd_bank  in  4/AW/2
- ref_en / wr_en / rd_en  out  1 each  grant pulses
- ref_pend  out  1  refresh waiting while write/read owns bus (burst-break hint)
- wdog_err  out  1  1-cycle pulse on watchdog release
- sdram_cmd / sdram_addr / sdram_bank  out  4/AW/2  muxed pins

Behaviour:
- Reset, synchronous on `rstn`=0 at `posedge clk`:
  - state=IDLE.
  - `ref_en`, `wr_en`, `rd_en`, `wdog_err` all 0.
  - `init_done` latch 0; watchdog counter 0.
  - Pins follow the IDLE mux (init inputs).
  - Reset mid-operation abandons the owner immediately; no completion is awaited.
- States: IDLE, ARBIT, AREF, WRITE, READ (encoding in package).
- IDLE:
  - Pins = init_*.
  - `flag_init_end`=1 sets `init_done` and moves to ARBIT next cycle.
  - Later `flag_init_end` values are ignored.
- ARBIT:
  - Pins = NOP, addr 0, bank 0.
  - Fixed priority ref > wr > rd.
  - Grant: assert the matching `*_en` for exactly one cycle, registered.
  - The state moves to AREF/WRITE/READ on the same edge `*_en` rises.
  - No request pending: stay in ARBIT.
- AREF / WRITE / READ:
  - Pins = owner's cmd/addr/bank, combinational mux of the registered state; 0 extra latency.
  - Exit to ARBIT on the edge after `flag_ref_end` / `wr_end` / `rd_end`.
  - Minimum one ARBIT cycle between owners, so back-to-back grants are ≥2 cycles apart.
  - `*_end` seen in the grant cycle itself is honoured.
  - `*_end` from a non-owner is ignored.
- `ref_pend` = `ref_req` & (state==WRITE | state==READ), combinational. The owner may end early on it.
- Watchdog:
  - Counter clears on entry to AREF/WRITE/READ and increments each cycle there.
  - When it reaches WDOG_MAX without an end pulse: return to ARBIT and pulse `wdog_err` 1 cycle.
  - Counter saturates and does not wrap.
- Simultaneous `ref_req`, `wr_req` and `rd_req` in ARBIT: only `ref_en`; wr/rd stay pending (their level held).
- Request dropped before grant: no grant issued.
- Requests still high after the grant are not re-granted until the next ARBIT cycle. Request modules must drop `req` on `*_en`.

Decomposition:
- Package `sdram_pkg`:
  - state enum.
  - Command codes NOP=0111, PRE=0010, AREF=0001, ACT=0011, WR=0100, RD=0101.
  - Address width AW.
- One sub-module `sdram_wdog`: loadable saturating counter with a terminal flag. Everything else stays inline.

Test Plan:
- Reset, then `flag_init_end` pulse at cycle 5:
  - pins = init_* through cycle 5;
  - state ARBIT at cycle 6;
  - pins `NOP`/0/0;
  - all enables 0.
- `ref_req`, `wr_req` and `rd_req` all high in ARBIT:
  - `ref_en`=1 for exactly one cycle;
  - `sdram_cmd` = `ref_cmd` (e.g. 0010 then 0001);
  - `flag_ref_end` → one NOP cycle, then `wr_en` pulse;
  - after `wr_end`, `rd_en`.
- In WRITE, raise `ref_req`:
  - `ref_pend`=1 the same cycle;
  - `wr_end` 3 cycles later → ARBIT → `ref_en` next cycle, before any pending `rd_req`.
- In READ, never pulse `rd_end` (WDOG_MAX=15):
  - `wdog_err`=1 for one cycle at cycle 15 after entry;
  - state ARBIT;
  - pins NOP.
- `rstn`=0 asserted mid-AREF:
  - next edge: state IDLE, enables 0, pins = init_*;
  - `ref_req` ignored until `flag_init_end`.
- `wr_end` pulsed while in READ: ignored, state stays READ. `rd_end` then exits normally.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM command arbiter slice.
package sdram_pkg;

  // SDRAM address width
  localparam int AW = 12;

  // Arbiter ownership states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_e;

  // {cs_n, ras_n, cas_n, we_n} command codes
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  // True while one of the sub-controllers holds the bus
  function automatic logic is_owner(state_e s);
    return (s == ST_AREF) || (s == ST_WRITE) || (s == ST_READ);
  endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Request/grant handshakes and command pins between the arbiter,
// its sub-controllers and the SDRAM pads.
interface sdram_arbiter_if;
  import sdram_pkg::*;

  logic          flag_init_end;
  logic [3:0]    init_cmd;
  logic [AW-1:0] init_addr;
  logic [1:0]    init_bank;

  logic          ref_req;
  logic          flag_ref_end;
  logic [3:0]    ref_cmd;
  logic [AW-1:0] ref_addr;
  logic [1:0]    ref_bank;

  logic          wr_req;
  logic          wr_end;
  logic [3:0]    wr_cmd;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_bank;

  logic          rd_req;
  logic          rd_end;
  logic [3:0]    rd_cmd;
  logic [AW-1:0] rd_addr;
  logic [1:0]    rd_bank;

  logic          ref_en;
  logic          wr_en;
  logic          rd_en;
  logic          ref_pend;
  logic          wdog_err;
  logic [3:0]    sdram_cmd;
  logic [AW-1:0] sdram_addr;
  logic [1:0]    sdram_bank;

  // Arbiter side
  modport slave (
    input  flag_init_end, init_cmd, init_addr, init_bank,
    input  ref_req, flag_ref_end, ref_cmd, ref_addr, ref_bank,
    input  wr_req, wr_end, wr_cmd, wr_addr, wr_bank,
    input  rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
    output ref_en, wr_en, rd_en, ref_pend, wdog_err,
    output sdram_cmd, sdram_addr, sdram_bank
  );

  // Sub-controller / pad side
  modport master (
    output flag_init_end, init_cmd, init_addr, init_bank,
    output ref_req, flag_ref_end, ref_cmd, ref_addr, ref_bank,
    output wr_req, wr_end, wr_cmd, wr_addr, wr_bank,
    output rd_req, rd_end, rd_cmd, rd_addr, rd_bank,
    input  ref_en, wr_en, rd_en, ref_pend, wdog_err,
    input  sdram_cmd, sdram_addr, sdram_bank
  );

endinterface

// File: rtl/sdram_wdog.sv
// Bus-hold watchdog: loadable saturating up-counter. term_o flags the
// cycle whose increment brings the count to MAX, so the caller can leave
// on exactly that edge.
module sdram_wdog #(
  parameter int MAX = 1023,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);

  localparam logic [CW-1:0] MAX_C  = CW'(MAX);
  localparam logic [CW-1:0] LAST_C = CW'(MAX - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Clear has priority; increment stops at MAX instead of wrapping
  always_comb begin
    if (clr_i) begin
      cnt_d = {CW{1'b0}};
    end else if (inc_i && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Terminal flag: this cycle's increment reaches MAX
  always_comb begin
    if (inc_i && (cnt_q >= LAST_C)) begin
      term_o = 1'b1;
    end else begin
      term_o = 1'b0;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Central SDRAM command arbiter: grants refresh/write/read ownership with
// fixed priority, muxes the owner's pins onto the pads and forces a
// release if an owner holds the bus too long.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int WDOG_MAX = 1023
) (
  input  logic           clk,
  input  logic           rstn,
  sdram_arbiter_if.slave bus
);

  state_e        state_q, state_d;
  logic          init_done_q, init_done_d;
  logic          ref_en_q, ref_en_d;
  logic          wr_en_q, wr_en_d;
  logic          rd_en_q, rd_en_d;
  logic          wdog_err_q, wdog_err_d;
  logic          owner_end_s;
  logic          wdog_clr_s, wdog_inc_s, wdog_term_s;
  logic [3:0]    pin_cmd_s;
  logic [AW-1:0] pin_addr_s;
  logic [1:0]    pin_bank_s;

  // Watchdog restarts on every grant and runs only while an owner holds the bus
  assign wdog_inc_s = is_owner(state_q);
  assign wdog_clr_s = (state_q == ST_ARBIT) && (state_d != ST_ARBIT);

  sdram_wdog #(
    .MAX (WDOG_MAX)
  ) u_wdog (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (wdog_clr_s),
    .inc_i  (wdog_inc_s),
    .term_o (wdog_term_s)
  );

  // State register plus registered grant and error pulses
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      init_done_q <= 1'b0;
      ref_en_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wdog_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      ref_en_q    <= ref_en_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      wdog_err_q  <= wdog_err_d;
    end
  end

  // Only the current owner's end pulse counts; others are ignored
  always_comb begin
    case (state_q)
      ST_AREF:  owner_end_s = bus.flag_ref_end;
      ST_WRITE: owner_end_s = bus.wr_end;
      ST_READ:  owner_end_s = bus.rd_end;
      default:  owner_end_s = 1'b0;
    endcase
  end

  // Next-state: init hand-off, fixed-priority grant, owner release
  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.flag_init_end || init_done_q) begin
          init_done_d = 1'b1;
          state_d     = ST_ARBIT;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_ARBIT: begin
        if (bus.ref_req) begin
          state_d = ST_AREF;
        end else if (bus.wr_req) begin
          state_d = ST_WRITE;
        end else if (bus.rd_req) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_ARBIT;
        end
      end
      ST_AREF, ST_WRITE, ST_READ: begin
        if (owner_end_s || wdog_term_s) begin
          state_d = ST_ARBIT;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: one-cycle grants, watchdog pulse, pin mux from registered state
  always_comb begin
    ref_en_d   = (state_q == ST_ARBIT) && bus.ref_req;
    wr_en_d    = (state_q == ST_ARBIT) && !bus.ref_req && bus.wr_req;
    rd_en_d    = (state_q == ST_ARBIT) && !bus.ref_req && !bus.wr_req && bus.rd_req;
    // A genuine end pulse in the same cycle wins over the watchdog
    wdog_err_d = is_owner(state_q) && wdog_term_s && !owner_end_s;
    case (state_q)
      ST_IDLE: begin
        pin_cmd_s  = bus.init_cmd;
        pin_addr_s = bus.init_addr;
        pin_bank_s = bus.init_bank;
      end
      ST_AREF: begin
        pin_cmd_s  = bus.ref_cmd;
        pin_addr_s = bus.ref_addr;
        pin_bank_s = bus.ref_bank;
      end
      ST_WRITE: begin
        pin_cmd_s  = bus.wr_cmd;
        pin_addr_s = bus.wr_addr;
        pin_bank_s = bus.wr_bank;
      end
      ST_READ: begin
        pin_cmd_s  = bus.rd_cmd;
        pin_addr_s = bus.rd_addr;
        pin_bank_s = bus.rd_bank;
      end
      default: begin
        pin_cmd_s  = CMD_NOP;
        pin_addr_s = {AW{1'b0}};
        pin_bank_s = 2'b00;
      end
    endcase
  end

  assign bus.ref_en     = ref_en_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.wdog_err   = wdog_err_q;
  assign bus.ref_pend   = bus.ref_req && ((state_q == ST_WRITE) || (state_q == ST_READ));
  assign bus.sdram_cmd  = pin_cmd_s;
  assign bus.sdram_addr = pin_addr_s;
  assign bus.sdram_bank = pin_bank_s;

endmodule
